// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory/MMIO slave port between the instruction
// bus (ibus) and data bus (dbus). Each grant latches a single transaction,
// holds it on the slave port until s_ready, then returns registered read data
// with a one-cycle ready pulse. dbus wins ties, but a starvation counter forces
// an ibus grant after STARVE_MAX consecutive dbus wins. A watchdog aborts a
// transaction whose slave never answers.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = 4,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_mask,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_mask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [MASK_W-1:0] s_mask,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic              grant_d
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER_I = 2'd1;
    localparam logic [1:0] ST_XFER_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM  = SC_W'(STARVE_MAX);
    localparam logic [7:0]      TIMEOUT_LIM = 8'(TIMEOUT);

    logic [1:0]        state_q,     state_d;
    logic [SC_W-1:0]   starveCnt_q, starveCnt_d;
    logic [7:0]        toCnt_q,     toCnt_d;
    logic [7:0]        toCntInc;
    logic              sReq_q,      sReq_d;
    logic              sWe_q,       sWe_d;
    logic [ADDR_W-1:0] sAddr_q,     sAddr_d;
    logic [DATA_W-1:0] sWdata_q,    sWdata_d;
    logic [MASK_W-1:0] sMask_q,     sMask_d;
    logic [DATA_W-1:0] iRdata_q,    iRdata_d;
    logic [DATA_W-1:0] dRdata_q,    dRdata_d;
    logic              iReady_q,    iReady_d;
    logic              iErr_q,      iErr_d;
    logic              dReady_q,    dReady_d;
    logic              dErr_q,      dErr_d;
    logic              grantD_q,    grantD_d;

    assign toCntInc = toCnt_q + 8'd1;

    // Next-state logic: arbitration in IDLE, slave handshake and watchdog in XFER, one-cycle response in RESP
    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        toCnt_d     = toCnt_q;
        sReq_d      = sReq_q;
        sWe_d       = sWe_q;
        sAddr_d     = sAddr_q;
        sWdata_d    = sWdata_q;
        sMask_d     = sMask_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        iReady_d    = 1'b0;
        iErr_d      = 1'b0;
        dReady_d    = 1'b0;
        dErr_d      = 1'b0;
        grantD_d    = grantD_q;

        case (state_q)
            ST_IDLE: begin
                grantD_d = 1'b0;
                toCnt_d  = '0;
                if (i_req && (!d_req || (starveCnt_q == STARVE_LIM))) begin
                    state_d     = ST_XFER_I;
                    sReq_d      = 1'b1;
                    sWe_d       = i_we;
                    sAddr_d     = i_addr;
                    sWdata_d    = i_wdata;
                    sMask_d     = i_mask;
                    starveCnt_d = '0;
                end else if (d_req) begin
                    state_d  = ST_XFER_D;
                    grantD_d = 1'b1;
                    sReq_d   = 1'b1;
                    sWe_d    = d_we;
                    sAddr_d  = d_addr;
                    sWdata_d = d_wdata;
                    sMask_d  = d_mask;
                    if (!i_req) begin
                        starveCnt_d = '0;
                    end else if (starveCnt_q != STARVE_LIM) begin
                        starveCnt_d = starveCnt_q + 1'b1;
                    end
                end
            end

            ST_XFER_I, ST_XFER_D: begin
                if (s_ready) begin
                    state_d = ST_RESP;
                    sReq_d  = 1'b0;
                    toCnt_d = '0;
                    if (state_q == ST_XFER_D) begin
                        dRdata_d = s_rdata;
                        dReady_d = 1'b1;
                    end else begin
                        iRdata_d = s_rdata;
                        iReady_d = 1'b1;
                    end
                end else if (toCntInc == TIMEOUT_LIM) begin
                    state_d = ST_RESP;
                    sReq_d  = 1'b0;
                    toCnt_d = '0;
                    if (state_q == ST_XFER_D) begin
                        dErr_d = 1'b1;
                    end else begin
                        iErr_d = 1'b1;
                    end
                end else begin
                    toCnt_d = toCntInc;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grantD_d = 1'b0;
            end
        endcase
    end

    // State and output registers; a reset abandons any transaction without a response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starveCnt_q <= '0;
            toCnt_q     <= '0;
            sReq_q      <= 1'b0;
            sWe_q       <= 1'b0;
            sAddr_q     <= '0;
            sWdata_q    <= '0;
            sMask_q     <= '0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            iReady_q    <= 1'b0;
            iErr_q      <= 1'b0;
            dReady_q    <= 1'b0;
            dErr_q      <= 1'b0;
            grantD_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            toCnt_q     <= toCnt_d;
            sReq_q      <= sReq_d;
            sWe_q       <= sWe_d;
            sAddr_q     <= sAddr_d;
            sWdata_q    <= sWdata_d;
            sMask_q     <= sMask_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
            iReady_q    <= iReady_d;
            iErr_q      <= iErr_d;
            dReady_q    <= dReady_d;
            dErr_q      <= dErr_d;
            grantD_q    <= grantD_d;
        end
    end

    assign s_req   = sReq_q;
    assign s_we    = sWe_q;
    assign s_addr  = sAddr_q;
    assign s_wdata = sWdata_q;
    assign s_mask  = sMask_q;
    assign i_rdata = iRdata_q;
    assign i_ready = iReady_q;
    assign i_err   = iErr_q;
    assign d_rdata = dRdata_q;
    assign d_ready = dReady_q;
    assign d_err   = dErr_q;
    assign grant_d = grantD_q;

endmodule
